// File: rtl/stream_rr_merge_arbiter_pkg.sv
// Shared types for the round-robin stream merge arbiter.
// FSM state encoding and index-width helper.
package stream_rr_merge_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_rr_merge_arbiter_pick.sv
// Round-robin picker: rotate requests by ptr, then priority-encode.
// Returns the first requester at or after ptr, wrapping.
module stream_rr_merge_arbiter_pick #(
    parameter int NUM_IN    = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [NUM_IN-1:0]    req_i,
    input  logic [IDX_WIDTH-1:0] ptr_i,
    output logic                 valid_o,
    output logic [IDX_WIDTH-1:0] idx_o
);

    logic [2*NUM_IN-1:0] dbl;
    logic [NUM_IN-1:0]   rot;
    int                  off;
    int                  sum;

    always_comb begin
        dbl     = {req_i, req_i};
        rot     = NUM_IN'(dbl >> ptr_i);
        valid_o = |rot;
        off     = 0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (rot[k]) off = k;
        end
        sum = int'(ptr_i) + off;
        if (sum >= NUM_IN) sum = sum - NUM_IN;
        idx_o = IDX_WIDTH'(sum);
    end

endmodule

// File: rtl/stream_rr_merge_arbiter.sv
// Merges NUM_IN FWFT streams into one FIFO write port, round-robin
// with bursts of up to MAX_BURST beats and a registered output.
module stream_rr_merge_arbiter
    import stream_rr_merge_arbiter_pkg::*;
#(
    parameter  int NUM_IN     = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int MAX_BURST  = 8,
    localparam int IDX_WIDTH  = clog2_min1(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_IN-1:0]            in_empty_n,
    output logic [NUM_IN-1:0]            in_read,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_dout,
    input  logic                         out_full_n,
    output logic                         out_write,
    output logic [DATA_WIDTH-1:0]        out_din,
    output logic [IDX_WIDTH-1:0]         out_src
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_IN - 1);

    arb_state_e            state_q;
    logic [IDX_WIDTH-1:0]  grant_q;
    logic [IDX_WIDTH-1:0]  rr_ptr_q;
    logic [IDX_WIDTH-1:0]  rr_ptr_d;
    logic [CNT_W-1:0]      beat_cnt_q;
    logic                  out_write_q;
    logic [DATA_WIDTH-1:0] out_din_q;
    logic [IDX_WIDTH-1:0]  out_src_q;

    logic                  pick_valid;
    logic [IDX_WIDTH-1:0]  pick_idx;
    logic                  pop;
    logic [DATA_WIDTH-1:0] din_arr [NUM_IN];

    for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
        assign din_arr[i] = in_dout[i*DATA_WIDTH +: DATA_WIDTH];
    end

    stream_rr_merge_arbiter_pick #(
        .NUM_IN    (NUM_IN),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick (
        .req_i   (in_empty_n),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign pop = (state_q == ARB_BURST) && in_empty_n[grant_q] && out_full_n;

    // Rotation target once the current grant is released
    assign rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_WIDTH'(1);

    always_comb begin
        in_read = '0;
        if (pop) in_read[grant_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            out_write_q <= 1'b0;
            out_din_q   <= '0;
            out_src_q   <= '0;
        end else begin
            out_write_q <= pop;
            if (pop) begin
                out_din_q <= din_arr[grant_q];
                out_src_q <= grant_q;
            end
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        grant_q    <= pick_idx;
                        beat_cnt_q <= '0;
                        state_q    <= ARB_BURST;
                    end
                end
                ARB_BURST: begin
                    if (pop) begin
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        if (beat_cnt_q == LAST_BEAT) begin
                            state_q  <= ARB_IDLE;
                            rr_ptr_q <= rr_ptr_d;
                        end
                    end else if (!in_empty_n[grant_q]) begin
                        state_q  <= ARB_IDLE;
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign out_write = out_write_q;
    assign out_din   = out_din_q;
    assign out_src   = out_src_q;

endmodule
